// File: rtl/build_info_pkg.sv
// Shared constants and types for the build-identification read block.
package build_info_pkg;

  localparam logic [1:0] ADDR_HASH_LO = 2'd0;
  localparam logic [1:0] ADDR_HASH_HI = 2'd1;
  localparam logic [1:0] ADDR_TS      = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam logic [15:0] STATUS_MAGIC = 16'hB1D0;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_QUAL,
    CAP_DONE
  } cap_state_e;

  function automatic logic [31:0] status_word(logic [2:0] nreq, logic tsv);
    return {STATUS_MAGIC, 5'b0, nreq, 7'b0, tsv};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered priority pointer that moves past the last winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/build_info_arb.sv
// Build-identity read port: qualifies USR_ACCESS into clk, holds it with the
// git hash, and serves round-robin single-word reads with one-cycle latency.
module build_info_arb
  import build_info_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int STABLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            hash_i,
  input  logic                   ua_datavalid_i,
  input  logic [31:0]            ua_data_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [2*NUM_REQ-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   rsp_valid_o,
  output logic [2:0]             rsp_id_o,
  output logic [31:0]            rsp_data_o,
  output logic                   ts_valid_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [2:0] NREQ3 = 3'(NUM_REQ);

  // Data path is only double-registered; the stability window below is what
  // makes the multi-bit word safe to use.
  logic        dv_meta, dv_sync;
  logic [31:0] ua_d1, ua_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_meta <= 1'b0;
      dv_sync <= 1'b0;
      ua_d1   <= '0;
      ua_d2   <= '0;
    end else begin
      dv_meta <= ua_datavalid_i;
      dv_sync <= dv_meta;
      ua_d1   <= ua_data_i;
      ua_d2   <= ua_d1;
    end
  end

  cap_state_e  cap_state;
  logic [7:0]  stable_cnt;
  logic [31:0] ref_word;
  logic [31:0] ts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state  <= CAP_IDLE;
      stable_cnt <= '0;
      ref_word   <= '0;
      ts_reg     <= '0;
      ts_valid_o <= 1'b0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          if (dv_sync) begin
            cap_state  <= CAP_QUAL;
            stable_cnt <= 8'd1;
            ref_word   <= ua_d2;
          end
        end
        CAP_QUAL: begin
          if (!dv_sync) begin
            cap_state <= CAP_IDLE;
          end else if (ua_d2 != ref_word) begin
            ref_word   <= ua_d2;
            stable_cnt <= 8'd1;
          end else if (stable_cnt == 8'(STABLE_CYC - 1)) begin
            ts_reg     <= ref_word;
            ts_valid_o <= 1'b1;
            cap_state  <= CAP_DONE;
          end else begin
            stable_cnt <= stable_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [63:0] hash_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hash_reg <= '0;
    else        hash_reg <= hash_i;
  end

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready_o = gnt;

  logic [NUM_REQ-1:0][1:0] addr_arr;
  logic [1:0]              sel_addr;
  logic [31:0]             rd_word;

  assign addr_arr = req_addr_i;

  // Mux reads the pre-edge ts_reg, so a read racing the capture sees 0.
  always_comb begin
    sel_addr = addr_arr[gnt_idx];
    rd_word  = '0;
    case (sel_addr)
      ADDR_HASH_LO: rd_word = hash_reg[31:0];
      ADDR_HASH_HI: rd_word = hash_reg[63:32];
      ADDR_TS:      rd_word = ts_reg;
      ADDR_STATUS:  rd_word = status_word(NREQ3, ts_valid_o);
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= |gnt;
      if (|gnt) begin
        rsp_id_o   <= 3'(gnt_idx);
        rsp_data_o <= rd_word;
      end
    end
  end

endmodule
